// File: rtl/mux_scan_n.sv
// mux_scan_n -- registered channel selector with manual and scanning modes.
//
// Selects one WIDTH-bit channel out of CHANNELS flattened inputs and presents
// it on a registered output stream. In manual mode the channel comes from
// `select`; in scan mode an internal pointer walks the enabled channels of
// `ch_mask` in increasing index order, taking DWELL captures on each one
// before moving on.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   en         : block enable (0 parks the block in IDLE)
//   mode       : 0 = manual, 1 = scan
//   select     : manual channel index (>= CHANNELS is treated as no channel)
//   ch_mask    : per-channel enable for scan mode, bit k enables channel k
//   datain     : flattened input data, channel k at [k*WIDTH +: WIDTH]
//   out_ready  : downstream accepts the current output
//   out        : registered selected data
//   out_ch     : index of the channel held in out
//   out_valid  : out / out_ch / scan_wrap are valid
//   scan_wrap  : set alongside the first capture of a new scan lap
//   dbg_state_o: current FSM state (IDLE=0, MANUAL=1, SCAN=2)
//
// Handshake: out/out_ch/scan_wrap form one transfer qualified by out_valid.
// A transfer completes on a rising edge with out_valid=1 and out_ready=1.
// Once out_valid=1 and out_ready=0 the whole transfer, the FSM state, the
// scan pointer and the dwell counter are frozen until out_ready rises. A
// "load opportunity" is any edge with out_valid=0 or out_ready=1; only then
// may anything visible change.

module mux_scan_n #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic [CHANNELS*WIDTH-1:0] datain,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  output logic                      scan_wrap,
  output logic [1:0]                dbg_state_o
);

  // Channel slots padded to the full index space so that any SEL_W-bit
  // index is a legal array/bit select; unused slots read as disabled/zero.
  localparam int NSLOT = 1 << SEL_W;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MANUAL = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  // The lap wrap is decided when the pointer advances, but it must be
  // reported with the first capture of the new channel one load later.
  logic             pend_q, pend_d;
  // Low for the first edge after reset so the first capture lands no
  // earlier than the second rising edge.
  logic             started_q;

  logic [NSLOT-1:0] mask_ext;
  logic [WIDTH-1:0] data_arr [NSLOT];

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < CHANNELS) begin : g_used
      assign mask_ext[k] = ch_mask[k];
      assign data_arr[k] = datain[k*WIDTH +: WIDTH];
    end else begin : g_unused
      assign mask_ext[k] = 1'b0;
      assign data_arr[k] = '0;
    end
  end

  // Next enabled channel strictly after `base`, circularly. When `base` is
  // the only enabled channel the search comes back to `base` itself.
  function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] base,
                                                     input logic [NSLOT-1:0] m);
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] cand;
    logic             found;
    res   = base;
    found = 1'b0;
    for (int off = 1; off <= CHANNELS; off++) begin
      cand = SEL_W'((int'(base) + off) % CHANNELS);
      if (!found && m[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [SEL_W-1:0] lowest_enabled(input logic [NSLOT-1:0] m);
    logic [SEL_W-1:0] res;
    res = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (m[SEL_W'(k)]) res = SEL_W'(k);
    end
    return res;
  endfunction

  logic             load;
  state_t           target;
  logic             entering;
  logic [SEL_W-1:0] base, cap, nxt;
  logic [CNT_W-1:0] cnt, cnt1;
  logic             wrap_now;

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    ch_d     = ch_q;
    valid_d  = valid_q;
    wrap_d   = wrap_q;
    ptr_d    = ptr_q;
    dwell_d  = dwell_q;
    pend_d   = pend_q;
    entering = 1'b0;
    base     = '0;
    cap      = '0;
    nxt      = '0;
    cnt      = '0;
    cnt1     = '0;
    wrap_now = 1'b0;

    load = started_q && (!valid_q || out_ready);

    // en outranks mode; mask and dwell handling only matter inside SCAN.
    if (!en)        target = S_IDLE;
    else if (!mode) target = S_MANUAL;
    else            target = S_SCAN;

    if (load) begin
      state_d = target;
      case (target)
        S_IDLE: begin
          valid_d = 1'b0;
          wrap_d  = 1'b0;
        end

        S_MANUAL: begin
          wrap_d = 1'b0;
          if (int'(select) < CHANNELS) begin
            out_d   = data_arr[select];
            ch_d    = select;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end

        default: begin // S_SCAN
          entering = (state_q != S_SCAN);
          if (ch_mask == '0) begin
            // Nothing to scan: drop valid, keep the pointer where it is.
            valid_d = 1'b0;
            wrap_d  = 1'b0;
            if (entering) begin
              dwell_d = '0;
              pend_d  = 1'b0;
            end
          end else begin
            base = entering ? lowest_enabled(mask_ext) : ptr_q;
            if (mask_ext[base]) begin
              cap      = base;
              cnt      = entering ? '0 : dwell_q;
              wrap_now = entering ? 1'b0 : pend_q;
            end else begin
              // Current channel was masked off: jump now, fresh dwell.
              cap      = next_enabled(base, mask_ext);
              cnt      = '0;
              wrap_now = (cap <= base);
            end
            cnt1    = cnt + CNT_W'(1);
            out_d   = data_arr[cap];
            ch_d    = cap;
            valid_d = 1'b1;
            wrap_d  = wrap_now;
            if (cnt1 == CNT_W'(DWELL)) begin
              nxt     = next_enabled(cap, mask_ext);
              ptr_d   = nxt;
              dwell_d = '0;
              pend_d  = (nxt <= cap);
            end else begin
              ptr_d   = cap;
              dwell_d = cnt1;
              pend_d  = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      ch_q      <= '0;
      valid_q   <= 1'b0;
      wrap_q    <= 1'b0;
      ptr_q     <= '0;
      dwell_q   <= '0;
      pend_q    <= 1'b0;
      started_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      wrap_q    <= wrap_d;
      ptr_q     <= ptr_d;
      dwell_q   <= dwell_d;
      pend_q    <= pend_d;
      started_q <= 1'b1;
    end
  end

  assign out         = out_q;
  assign out_ch      = ch_q;
  assign out_valid   = valid_q;
  assign scan_wrap   = wrap_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Testbench for mux_scan_n. Main instance: 8 channels, DWELL=2. A second
// instance with 6 channels covers the out-of-range manual select.
// Channel data 0..7 = 15,12,10,9,5,2,8,4.

module tb_mux_scan_n;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // ---------------- main DUT (8 ch, DWELL=2) ----------------
  logic        rst, en, mode, out_ready;
  logic [2:0]  select;
  logic [7:0]  ch_mask;
  logic [31:0] datain;
  logic [3:0]  out;
  logic [2:0]  out_ch;
  logic        out_valid, scan_wrap;
  logic [1:0]  dbg_state;

  mux_scan_n #(.WIDTH(4), .CHANNELS(8), .SEL_W(3), .DWELL(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .select(select),
    .ch_mask(ch_mask), .datain(datain), .out_ready(out_ready),
    .out(out), .out_ch(out_ch), .out_valid(out_valid),
    .scan_wrap(scan_wrap), .dbg_state_o(dbg_state)
  );

  // ---------------- 6-channel DUT ----------------
  logic        rst6, en6, mode6, ready6;
  logic [2:0]  select6;
  logic [5:0]  mask6;
  logic [23:0] datain6;
  logic [3:0]  out6;
  logic [2:0]  out_ch6;
  logic        valid6, wrap6;
  logic [1:0]  dbg_state6;

  mux_scan_n #(.WIDTH(4), .CHANNELS(6), .SEL_W(3), .DWELL(4)) u_dut6 (
    .clk(clk), .rst(rst6), .en(en6), .mode(mode6), .select(select6),
    .ch_mask(mask6), .datain(datain6), .out_ready(ready6),
    .out(out6), .out_ch(out_ch6), .out_valid(valid6),
    .scan_wrap(wrap6), .dbg_state_o(dbg_state6)
  );

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; en = 1'b1; mode = 1'b0; select = 3'd3;
    out_ready = 1'b1; ch_mask = 8'hA5;
    @(negedge clk);
    n_vec++; if (out !== 4'd0)    begin n_err++; $display("FAIL rst_out got %0d want 0", out); end
    n_vec++; if (out_ch !== 3'd0) begin n_err++; $display("FAIL rst_out_ch got %0d want 0", out_ch); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    n_vec++; if (scan_wrap !== 1'b0) begin n_err++; $display("FAIL rst_wrap got %0b want 0", scan_wrap); end
    rst = 1'b0;
    // First edge after release must not capture.
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_edge_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_manual;
    @(negedge clk);
    n_vec++; if (out !== 4'd9 || out_ch !== 3'd3 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL manual_sel3 got out=%0d ch=%0d v=%0b want 9/3/1", out, out_ch, out_valid);
    end
    select = 3'd7;
    @(negedge clk);
    n_vec++; if (out !== 4'd4 || out_ch !== 3'd7 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL manual_sel7 got out=%0d ch=%0d v=%0b want 4/7/1", out, out_ch, out_valid);
    end
  endtask

  task automatic test_scan;
    logic [3:0] exp_out [11];
    logic [2:0] exp_ch  [11];
    exp_out = '{4'd15, 4'd15, 4'd10, 4'd10, 4'd2, 4'd2, 4'd4, 4'd4, 4'd15, 4'd15, 4'd10};
    exp_ch  = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd5, 3'd5, 3'd7, 3'd7, 3'd0, 3'd0, 3'd2};
    mode = 1'b1; ch_mask = 8'hA5;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      n_vec++; if (out !== exp_out[i] || out_ch !== exp_ch[i] || out_valid !== 1'b1) begin
        n_err++; $display("FAIL scan_seq[%0d] got out=%0d ch=%0d v=%0b want %0d/%0d/1",
                          i, out, out_ch, out_valid, exp_out[i], exp_ch[i]);
      end
      n_vec++; if (scan_wrap !== (i == 8)) begin
        n_err++; $display("FAIL scan_wrap[%0d] got %0b want %0b", i, scan_wrap, (i == 8));
      end
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] exp_out [6];
    logic [2:0] exp_ch  [6];
    exp_out = '{4'd10, 4'd2, 4'd2, 4'd4, 4'd4, 4'd15};
    exp_ch  = '{3'd2, 3'd5, 3'd5, 3'd7, 3'd7, 3'd0};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (out !== 4'd10 || out_ch !== 3'd2 || out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold[%0d] got out=%0d ch=%0d v=%0b want 10/2/1", i, out, out_ch, out_valid);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++; if (out !== exp_out[i] || out_ch !== exp_ch[i] || scan_wrap !== (i == 5)) begin
        n_err++; $display("FAIL bp_resume[%0d] got out=%0d ch=%0d w=%0b want %0d/%0d/%0b",
                          i, out, out_ch, scan_wrap, exp_out[i], exp_ch[i], (i == 5));
      end
    end
  endtask

  task automatic test_mask;
    // ch0 is one capture into its dwell; drop it from the mask.
    ch_mask = 8'hA4;
    @(negedge clk);
    n_vec++; if (out !== 4'd10 || out_ch !== 3'd2 || scan_wrap !== 1'b0) begin
      n_err++; $display("FAIL mask_skip got out=%0d ch=%0d w=%0b want 10/2/0", out, out_ch, scan_wrap);
    end
    @(negedge clk);
    n_vec++; if (out !== 4'd10 || out_ch !== 3'd2) begin
      n_err++; $display("FAIL mask_dwell got out=%0d ch=%0d want 10/2", out, out_ch);
    end
    @(negedge clk);
    n_vec++; if (out !== 4'd2 || out_ch !== 3'd5) begin
      n_err++; $display("FAIL mask_next got out=%0d ch=%0d want 2/5", out, out_ch);
    end
    ch_mask = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL mask_zero[%0d] got v=%0b want 0", i, out_valid);
      end
    end
    ch_mask = 8'hA5;
    @(negedge clk);
    n_vec++; if (out !== 4'd2 || out_ch !== 3'd5 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL mask_restore got out=%0d ch=%0d v=%0b want 2/5/1", out, out_ch, out_valid);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out !== 4'd0 || out_ch !== 3'd0 || out_valid !== 1'b0 || scan_wrap !== 1'b0) begin
      n_err++; $display("FAIL async_rst got out=%0d ch=%0d v=%0b w=%0b want 0/0/0/0",
                        out, out_ch, out_valid, scan_wrap);
    end
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; ch_mask = 8'hA4;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_holdoff got v=%0b want 0", out_valid);
    end
    @(negedge clk);
    n_vec++; if (out !== 4'd10 || out_ch !== 3'd2 || out_valid !== 1'b1 || scan_wrap !== 1'b0) begin
      n_err++; $display("FAIL scan_restart got out=%0d ch=%0d v=%0b w=%0b want 10/2/1/0",
                        out, out_ch, out_valid, scan_wrap);
    end
  endtask

  task automatic test_illegal_select;
    rst6 = 1'b0; en6 = 1'b1; mode6 = 1'b0; select6 = 3'd6; ready6 = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (valid6 !== 1'b0) begin
      n_err++; $display("FAIL sel6_valid got %0b want 0", valid6);
    end
    select6 = 3'd5;
    @(negedge clk);
    n_vec++; if (out6 !== 4'd2 || out_ch6 !== 3'd5 || valid6 !== 1'b1) begin
      n_err++; $display("FAIL sel5 got out=%0d ch=%0d v=%0b want 2/5/1", out6, out_ch6, valid6);
    end
    select6 = 3'd7;
    @(negedge clk);
    n_vec++; if (valid6 !== 1'b0) begin
      n_err++; $display("FAIL sel7_valid got %0b want 0", valid6);
    end
    select6 = 3'd0;
    @(negedge clk);
    n_vec++; if (out6 !== 4'd15 || out_ch6 !== 3'd0 || valid6 !== 1'b1) begin
      n_err++; $display("FAIL sel0 got out=%0d ch=%0d v=%0b want 15/0/1", out6, out_ch6, valid6);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    datain  = 32'h4825_9ACF;
    datain6 = 24'h25_9ACF;
    rst6 = 1'b1; en6 = 1'b0; mode6 = 1'b0; select6 = 3'd0; ready6 = 1'b1; mask6 = 6'h3F;
    test_reset();
    test_manual();
    test_scan();
    test_backpressure();
    test_mask();
    test_async_reset();
    test_illegal_select();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
